// File: rtl/wb_sequencer_pkg.sv
// Purpose: shared instruction-format codes, sequencer state encoding and writeback selection helper.
// Latency: none; types and pure functions only, they reduce to small muxes where used.
// Backpressure: not applicable.
package wb_sequencer_pkg;

    // Instruction format codes; the operand builder emits these on instr_type.
    typedef enum logic [3:0] {
        IT_R = 4'd0,
        IT_I = 4'd1,
        IT_S = 4'd2,
        IT_B = 4'd3,
        IT_U = 4'd4,
        IT_J = 4'd5,
        IT_N = 4'd7
    } instr_type_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_REQ  = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_WB       = 2'd3
    } seq_state_e;

    // Link value for J-type is the address of the following instruction.
    localparam logic [31:0] LINK_OFFSET = 32'd4;

    // Operand bundle used to choose writeback data.
    typedef struct packed {
        logic [3:0]  itype;
        logic        is_load;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [31:0] imm;
    } op_t;

    typedef struct packed {
        logic        we;
        logic [31:0] data;
    } wb_sel_t;

    // Unused format codes collapse to N so they retire without a write.
    function automatic instr_type_e decode_type(input logic [3:0] code);
        instr_type_e t;
        case (code)
            4'd0:    t = IT_R;
            4'd1:    t = IT_I;
            4'd2:    t = IT_S;
            4'd3:    t = IT_B;
            4'd4:    t = IT_U;
            4'd5:    t = IT_J;
            default: t = IT_N;
        endcase
        return t;
    endfunction

    // Writeback decision for everything except load data; loads report we=0
    // here because their data arrives later from memory.
    function automatic wb_sel_t select_wb(input op_t op);
        wb_sel_t sel;
        sel.we   = 1'b0;
        sel.data = op.alu;
        case (decode_type(op.itype))
            IT_R: sel.we = 1'b1;
            IT_I: sel.we = ~op.is_load;
            IT_U: begin
                sel.we   = 1'b1;
                sel.data = op.imm;
            end
            IT_J: begin
                sel.we   = 1'b1;
                sel.data = op.pc + LINK_OFFSET;
            end
            default: sel.we = 1'b0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/wb_sequencer.sv
// Purpose: retires one instruction per accepted start; non-loads write back directly, loads issue one memory read first.
// Latency: non-load retires the cycle after start; load pulses mem_req the cycle after start and retires the cycle after mem_rvalid, or pulses err after MEM_TIMEOUT empty wait cycles.
// Backpressure: none; start is dropped (not queued) while busy is high, so the issuer must watch busy.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   start, instr_type, is_load  request and its format qualifiers
//   alu_result, pc, imm, rd_addr operands sampled on the accepting edge
//   mem_req/mem_addr            load request pulse and held address
//   mem_rdata/mem_rvalid        load return, only honoured while waiting
//   rd_we/rd_waddr/rd_wdata     register-file write port (address/data hold between writes)
//   busy, done, err             status: not idle, retire pulse, load timeout pulse
module wb_sequencer
    import wb_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  instr_type,
    input  logic        is_load,
    input  logic [31:0] alu_result,
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        rd_we,
    output logic [4:0]  rd_waddr,
    output logic [31:0] rd_wdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int               CNT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT);

    seq_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [4:0]       ld_rd_q;     // destination of the outstanding load
    logic             mem_req_q;
    logic [31:0]      mem_addr_q;  // doubles as the captured load address
    logic             rd_we_q;
    logic [4:0]       rd_waddr_q;
    logic [31:0]      rd_wdata_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    op_t              op_d;
    wb_sel_t          wb_d;
    logic             load_d;
    logic [CNT_W-1:0] cnt_d;

    // Non-load results are fully determined by the operands on the accepting
    // edge, so they are computed here and captured straight into the output
    // registers; that lets the write appear in the very next cycle.
    always_comb begin
        op_d         = '0;
        op_d.itype   = instr_type;
        op_d.is_load = is_load;
        op_d.alu     = alu_result;
        op_d.pc      = pc;
        op_d.imm     = imm;
        wb_d         = select_wb(op_d);
        load_d       = (decode_type(instr_type) == IT_I) && is_load;
        cnt_d        = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ld_rd_q    <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            rd_we_q    <= 1'b0;
            rd_waddr_q <= '0;
            rd_wdata_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // Pulse outputs default low; each state raises only its own.
            mem_req_q <= 1'b0;
            rd_we_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (load_d) begin
                            state_q    <= ST_MEM_REQ;
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= alu_result;
                            ld_rd_q    <= rd_addr;
                        end else begin
                            state_q <= ST_WB;
                            done_q  <= 1'b1;
                            // x0 is hardwired; retire without touching the port.
                            if (wb_d.we && (rd_addr != 5'd0)) begin
                                rd_we_q    <= 1'b1;
                                rd_waddr_q <= rd_addr;
                                rd_wdata_q <= wb_d.data;
                            end
                        end
                    end
                end

                ST_MEM_REQ: begin
                    state_q <= ST_MEM_WAIT;
                    cnt_q   <= '0;
                end

                ST_MEM_WAIT: begin
                    // Data takes priority over a timeout landing on the same edge.
                    if (mem_rvalid) begin
                        state_q <= ST_WB;
                        done_q  <= 1'b1;
                        if (ld_rd_q != 5'd0) begin
                            rd_we_q    <= 1'b1;
                            rd_waddr_q <= ld_rd_q;
                            rd_wdata_q <= mem_rdata;
                        end
                    end else if (cnt_d == CNT_LAST) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                        cnt_q   <= cnt_d;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                ST_WB: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign rd_we    = rd_we_q;
    assign rd_waddr = rd_waddr_q;
    assign rd_wdata = rd_wdata_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_wb_sequencer.sv
// Purpose: self-checking bench for wb_sequencer using a per-cycle expected timeline plus literal pins.
// Latency: expectations are placed at absolute cycle numbers derived from the issue cycle.
// Backpressure: stimulus only presents start when the sequencer is idle, except deliberate ignored starts.
module tb_wb_sequencer;

    localparam int NC     = 1024;
    localparam int NP     = 64;
    localparam int S_WE   = 0;
    localparam int S_WA   = 1;
    localparam int S_WD   = 2;
    localparam int S_DONE = 3;
    localparam int S_ERR  = 4;
    localparam int S_BUSY = 5;
    localparam int S_REQ  = 6;
    localparam int S_ADDR = 7;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  instr_type;
    logic        is_load;
    logic [31:0] alu_result;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd_addr;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        rd_we;
    logic [4:0]  rd_waddr;
    logic [31:0] rd_wdata;
    logic        busy;
    logic        done;
    logic        err;

    wb_sequencer #(.MEM_TIMEOUT(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .instr_type (instr_type),
        .is_load    (is_load),
        .alu_result (alu_result),
        .pc         (pc),
        .imm        (imm),
        .rd_addr    (rd_addr),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .rd_we      (rd_we),
        .rd_waddr   (rd_waddr),
        .rd_wdata   (rd_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    int cyc    = 0;
    int n_chk  = 0;
    int n_pass = 0;

    // Expected timeline, indexed by cycle number (cycle c = time after the c-th rising edge).
    bit          e_busy[NC];
    bit          e_done[NC];
    bit          e_we[NC];
    bit          e_err[NC];
    bit          e_req[NC];
    bit          e_wset[NC];
    logic [4:0]  e_wa[NC];
    logic [31:0] e_wd[NC];
    bit          e_aset[NC];
    logic [31:0] e_ad[NC];

    // Hand-computed literal expectations.
    int          pin_n = 0;
    int          pin_c[NP];
    int          pin_s[NP];
    logic [31:0] pin_v[NP];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s @cycle %0d: got 0x%08h, expected 0x%08h", nm, cyc, act, exp);
    endfunction

    function automatic string sig_nm(input int s);
        case (s)
            S_WE:    return "rd_we";
            S_WA:    return "rd_waddr";
            S_WD:    return "rd_wdata";
            S_DONE:  return "done";
            S_ERR:   return "err";
            S_BUSY:  return "busy";
            S_REQ:   return "mem_req";
            default: return "mem_addr";
        endcase
    endfunction

    function automatic logic [31:0] sig_val(input int s);
        case (s)
            S_WE:    return 32'(rd_we);
            S_WA:    return 32'(rd_waddr);
            S_WD:    return rd_wdata;
            S_DONE:  return 32'(done);
            S_ERR:   return 32'(err);
            S_BUSY:  return 32'(busy);
            S_REQ:   return 32'(mem_req);
            default: return mem_addr;
        endcase
    endfunction

    // Architectural write rule for a non-load retire.
    function automatic void model_write(input logic [3:0] t, input logic [31:0] alu, input logic [31:0] pcv,
                                        input logic [31:0] immv, input logic [4:0] rd,
                                        output bit we, output logic [31:0] d);
        we = 1'b0;
        d  = 32'd0;
        if (t == 4'd0 || t == 4'd1) begin we = 1'b1; d = alu;          end
        if (t == 4'd4)              begin we = 1'b1; d = immv;         end
        if (t == 4'd5)              begin we = 1'b1; d = pcv + 32'd4;  end
        if (rd == 5'd0) we = 1'b0;
    endfunction

    // Single compare process: every cycle, outputs against the timeline and pins.
    initial begin : compare
        logic [4:0]  m_wa;
        logic [31:0] m_wd;
        logic [31:0] m_ad;
        m_wa = '0;
        m_wd = '0;
        m_ad = '0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                m_wa = '0;
                m_wd = '0;
                m_ad = '0;
                chk("reset rd_we",    32'(rd_we),    32'd0);
                chk("reset rd_waddr", 32'(rd_waddr), 32'd0);
                chk("reset rd_wdata", rd_wdata,      32'd0);
                chk("reset done",     32'(done),     32'd0);
                chk("reset err",      32'(err),      32'd0);
                chk("reset busy",     32'(busy),     32'd0);
                chk("reset mem_req",  32'(mem_req),  32'd0);
                chk("reset mem_addr", mem_addr,      32'd0);
            end else if (cyc < NC) begin
                if (e_wset[cyc]) begin
                    m_wa = e_wa[cyc];
                    m_wd = e_wd[cyc];
                end
                if (e_aset[cyc]) m_ad = e_ad[cyc];
                chk("rd_we",    32'(rd_we),    32'(e_we[cyc]));
                chk("rd_waddr", 32'(rd_waddr), 32'(m_wa));
                chk("rd_wdata", rd_wdata,      m_wd);
                chk("done",     32'(done),     32'(e_done[cyc]));
                chk("err",      32'(err),      32'(e_err[cyc]));
                chk("busy",     32'(busy),     32'(e_busy[cyc]));
                chk("mem_req",  32'(mem_req),  32'(e_req[cyc]));
                chk("mem_addr", mem_addr,      m_ad);
                for (int i = 0; i < pin_n; i++)
                    if (pin_c[i] == cyc) chk({"pin ", sig_nm(pin_s[i])}, sig_val(pin_s[i]), pin_v[i]);
            end
        end
    end

    task automatic pin(input int c, input int s, input logic [31:0] v);
        pin_c[pin_n] = c;
        pin_s[pin_n] = s;
        pin_v[pin_n] = v;
        pin_n = pin_n + 1;
    endtask

    task automatic scramble();
        instr_type = 4'($urandom);
        is_load    = 1'($urandom);
        alu_result = $urandom;
        pc         = $urandom;
        imm        = $urandom;
        rd_addr    = 5'($urandom);
    endtask

    task automatic present(input logic [3:0] t, input logic ld, input logic [31:0] alu,
                           input logic [31:0] pcv, input logic [31:0] immv, input logic [4:0] rd);
        instr_type = t;
        is_load    = ld;
        alu_result = alu;
        pc         = pcv;
        imm        = immv;
        rd_addr    = rd;
        start      = 1'b1;
    endtask

    // Called at a negedge while idle; returns two cycles later with the sequencer idle again.
    task automatic op_nl(input logic [3:0] t, input logic [31:0] alu, input logic [31:0] pcv,
                         input logic [31:0] immv, input logic [4:0] rd);
        int          k;
        bit          we;
        logic [31:0] d;
        k = cyc;
        present(t, 1'b0, alu, pcv, immv, rd);
        model_write(t, alu, pcv, immv, rd, we, d);
        e_busy[k+1] = 1'b1;
        e_done[k+1] = 1'b1;
        if (we) begin
            e_we[k+1]   = 1'b1;
            e_wset[k+1] = 1'b1;
            e_wa[k+1]   = rd;
            e_wd[k+1]   = d;
        end
        @(negedge clk);
        start = 1'b0;
        scramble();
        @(negedge clk);
    endtask

    // Load: data is presented dly cycles after the mem_req cycle (if give); poke pulses an ignored start.
    task automatic op_load(input logic [31:0] addr, input logic [4:0] rd, input int dly,
                           input bit give, input logic [31:0] data, input bit poke);
        int k;
        int j;
        int endc;
        k = cyc;
        present(4'd1, 1'b1, addr, $urandom, $urandom, rd);
        e_req[k+1]  = 1'b1;
        e_aset[k+1] = 1'b1;
        e_ad[k+1]   = addr;
        if (give && dly <= 16) begin
            j = k + 1 + dly;
            for (int c = k + 1; c <= j + 1; c++) e_busy[c] = 1'b1;
            e_done[j+1] = 1'b1;
            if (rd != 5'd0) begin
                e_we[j+1]   = 1'b1;
                e_wset[j+1] = 1'b1;
                e_wa[j+1]   = rd;
                e_wd[j+1]   = data;
            end
            endc = j + 1;
        end else begin
            for (int c = k + 1; c <= k + 17; c++) e_busy[c] = 1'b1;
            e_err[k+18] = 1'b1;
            endc = give ? k + 2 + dly : k + 18;
        end
        @(negedge clk);
        start      = 1'b0;
        scramble();
        mem_rvalid = 1'b1;           // arrives while still requesting: must be ignored
        mem_rdata  = 32'hBAD0_BAD0;
        while (cyc < endc) begin
            @(negedge clk);
            mem_rvalid = give && (cyc == k + 1 + dly);
            mem_rdata  = mem_rvalid ? data : $urandom;
            start      = poke && (cyc == k + 3);
        end
        @(negedge clk);
        mem_rvalid = 1'b0;
        start      = 1'b0;
    endtask

    initial begin : main
        int k;
        rst_n      = 1'b0;
        start      = 1'b0;
        instr_type = 4'd0;
        is_load    = 1'b0;
        alu_result = 32'd0;
        pc         = 32'd0;
        imm        = 32'd0;
        rd_addr    = 5'd0;
        mem_rdata  = 32'd0;
        mem_rvalid = 1'b0;
        repeat (2) @(negedge clk);

        // R-type accepted on the first edge after reset release.
        k = cyc;
        pin(k + 1, S_WE, 32'd1);
        pin(k + 1, S_WA, 32'd5);
        pin(k + 1, S_WD, 32'h0000_00FF);
        pin(k + 1, S_DONE, 32'd1);
        pin(k + 2, S_BUSY, 32'd0);
        fork
            op_nl(4'd0, 32'h0000_00FF, 32'h100, 32'h0, 5'd5);
            begin
                #2;
                rst_n = 1'b1;
            end
        join

        // Stray load data while idle.
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_CAFE;
        @(negedge clk);
        mem_rvalid = 1'b0;
        @(negedge clk);

        // Back-to-back non-loads of every format.
        op_nl(4'd1, 32'h0000_1234, 32'h200, 32'h55, 5'd9);
        op_nl(4'd4, 32'h1111_1111, 32'h204, 32'hABCD_E000, 5'd10);
        k = cyc;
        pin(k + 1, S_WD, 32'h0000_0000);
        pin(k + 1, S_WA, 32'd1);
        op_nl(4'd5, 32'h2222_2222, 32'hFFFF_FFFC, 32'h8, 5'd1);
        k = cyc;
        pin(k + 1, S_WE, 32'd0);
        pin(k + 1, S_DONE, 32'd1);
        op_nl(4'd0, 32'h3333_3333, 32'h20C, 32'h0, 5'd0);
        k = cyc;
        pin(k + 1, S_DONE, 32'd1);
        pin(k + 1, S_WE, 32'd0);
        pin(k + 1, S_WA, 32'd1);
        pin(k + 1, S_WD, 32'h0000_0000);
        op_nl(4'd2, 32'h4444_4444, 32'h210, 32'h10, 5'd4);
        op_nl(4'd3, 32'h5555_5555, 32'h214, 32'h20, 5'd6);
        op_nl(4'd6, 32'h6666_6666, 32'h218, 32'h30, 5'd8);
        op_nl(4'd7, 32'h7777_7777, 32'h21C, 32'h40, 5'd11);

        // Load, data 4 cycles after mem_req, with an ignored start while waiting.
        k = cyc;
        pin(k + 1, S_REQ, 32'd1);
        pin(k + 4, S_ADDR, 32'h0000_1000);
        pin(k + 5, S_ADDR, 32'h0000_1000);
        pin(k + 6, S_WE, 32'd1);
        pin(k + 6, S_WA, 32'd3);
        pin(k + 6, S_WD, 32'hDEAD_BEEF);
        pin(k + 7, S_BUSY, 32'd0);
        op_load(32'h0000_1000, 5'd3, 4, 1'b1, 32'hDEAD_BEEF, 1'b1);

        // Load that never gets data.
        k = cyc;
        pin(k + 17, S_BUSY, 32'd1);
        pin(k + 18, S_ERR, 32'd1);
        pin(k + 18, S_BUSY, 32'd0);
        pin(k + 18, S_DONE, 32'd0);
        op_load(32'h0000_2000, 5'd7, 0, 1'b0, 32'h0, 1'b0);

        // Data on the same edge the count expires: data wins.
        k = cyc;
        pin(k + 18, S_ERR, 32'd0);
        pin(k + 18, S_WE, 32'd1);
        pin(k + 18, S_WD, 32'h0000_55AA);
        op_load(32'h0000_3000, 5'd12, 16, 1'b1, 32'h0000_55AA, 1'b0);

        // Data one cycle too late: timeout, then the data is ignored.
        k = cyc;
        pin(k + 18, S_ERR, 32'd1);
        pin(k + 19, S_WE, 32'd0);
        op_load(32'h0000_4000, 5'd13, 17, 1'b1, 32'h0BAD_F00D, 1'b0);

        // Fastest possible load and a load to x0.
        op_load(32'h0000_5000, 5'd14, 1, 1'b1, 32'h1357_9BDF, 1'b0);
        op_load(32'h0000_6000, 5'd0, 3, 1'b1, 32'h2468_ACE0, 1'b0);

        // Reset while waiting for load data, then late data.
        k = cyc;
        pin(k + 5, S_WE, 32'd0);
        pin(k + 5, S_BUSY, 32'd0);
        pin(k + 5, S_ADDR, 32'd0);
        pin(k + 5, S_WD, 32'd0);
        present(4'd1, 1'b1, 32'h0000_7000, 32'h300, 32'h0, 5'd6);
        e_req[k+1]  = 1'b1;
        e_aset[k+1] = 1'b1;
        e_ad[k+1]   = 32'h0000_7000;
        for (int c = k + 1; c <= k + 3; c++) e_busy[c] = 1'b1;
        @(negedge clk);
        start = 1'b0;
        scramble();
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFEED_FACE;
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
        @(negedge clk);

        // Normal operation resumes.
        k = cyc;
        pin(k + 1, S_WD, 32'h0000_0077);
        op_nl(4'd0, 32'h0000_0077, 32'h400, 32'h0, 5'd2);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
